kbd_scan_controller: RTL and testbench

- Sits between the PS/2 byte receiver and the CPU keyboard I/O register.
- Consumes raw scan-code bytes (Set 2), sequences the prefix protocol (E0 extended, F0 break, E1 pause) and drops controller chatter (AA/FA/FE/EE/00/FF).
- Pushes decoded key events into a small FIFO, which the CPU drains with a read strobe.

---
 rtl/kbd_scan_controller.sv | 174 +++++++++++++++++
 tb/tb_kbd_scan_controller.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------------------------+
// | kbd_scan_controller: Set 2 scan-byte sequencer with event FIFO; opt. KBD_REPEAT_FILTER_EN |
// | Revision 1.0                                                                              |
// +-----------------------------------------------------------------------------------------+
module kbd_scan_controller #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid_in,
  input  logic                        rd_in,
  input  logic                        clr_ovf_in,
  output logic [9:0]                  event_out,
  output logic                        empty_out,
  output logic [$clog2(FIFO_DEPTH):0] count_out,
  output logic                        overflow_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} state_t;

  state_t           state;
  logic [2:0]       skip;
  logic [TMR_W-1:0] tmr;
  logic             is_chatter;
  logic             dec_valid;
  logic [9:0]       dec_event;
  logic             push;

  always_comb begin
    case (byte_in)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_chatter = 1'b1;
      default:                                  is_chatter = 1'b0;
    endcase
  end

  // Events are decoded in the same cycle the final byte is sampled.
  always_comb begin
    dec_valid = 1'b0;
    dec_event = {2'b00, byte_in};
    if (byte_valid_in) begin
      case (state)
        S_IDLE:    dec_valid = !is_chatter && byte_in != 8'hE0 && byte_in != 8'hF0 && byte_in != 8'hE1;
        S_EXT: begin
          dec_valid = byte_in != 8'hF0 && byte_in != 8'hE0;
          dec_event = {2'b01, byte_in};
        end
        S_BRK: begin
          dec_valid = 1'b1;
          dec_event = {2'b10, byte_in};
        end
        S_EXT_BRK: begin
          dec_valid = 1'b1;
          dec_event = {2'b11, byte_in};
        end
        S_PAUSE: begin
          dec_valid = (skip == 3'd1);
          dec_event = {2'b01, 8'hE1};
        end
        default: dec_valid = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      skip  <= 3'd0;
      tmr   <= '0;
    end else if (byte_valid_in) begin
      tmr <= '0;
      case (state)
        S_IDLE: begin
          if (byte_in == 8'hE0)      state <= S_EXT;
          else if (byte_in == 8'hF0) state <= S_BRK;
          else if (byte_in == 8'hE1) begin
            state <= S_PAUSE;
            skip  <= 3'd7;
          end
        end
        S_EXT: begin
          if (byte_in == 8'hF0)      state <= S_EXT_BRK;
          else if (byte_in != 8'hE0) state <= S_IDLE;
        end
        S_PAUSE: begin
          skip <= skip - 3'd1;
          if (skip == 3'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end else if (state != S_IDLE) begin
      if (tmr == TMR_LAST) begin
        state <= S_IDLE;
        tmr   <= '0;
      end else begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

`ifdef KBD_REPEAT_FILTER_EN
  logic       held_valid;
  logic [8:0] held_key;
  logic       key_match;

  assign key_match = held_valid && (dec_event[8:0] == held_key);
  assign push      = dec_valid && (dec_event[9] || !key_match);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      held_valid <= 1'b0;
      held_key   <= '0;
    end else if (dec_valid) begin
      if (!dec_event[9] && !key_match) begin
        held_valid <= 1'b1;
        held_key   <= dec_event[8:0];
      end else if (dec_event[9] && key_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push = dec_valid;
`endif

  logic [9:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic [9:0]       last_head;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full      = (count == CNT_FULL);
  assign empty_out = (count == '0);
  assign count_out = count;
  assign do_pop    = rd_in && !empty_out;
  assign do_push   = push && (!full || do_pop);
  // Fall-through head; the last shown value is kept once the FIFO drains.
  assign event_out = empty_out ? last_head : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= dec_event;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      last_head    <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (!do_push && do_pop) count <= count - (PTR_W+1)'(1);
      if (!empty_out) last_head <= mem[rd_ptr];
      if (push && full && !do_pop) overflow_out <= 1'b1;
      else if (clr_ovf_in)         overflow_out <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized bench for kbd_scan_controller against a sequence-level reference model.
module tb_kbd_scan_controller;

  localparam int DEPTH = 8;
  localparam int TMO   = 16;
`ifdef KBD_REPEAT_FILTER_EN
  localparam int REP_EVENTS = 3;
`else
  localparam int REP_EVENTS = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb  = 8'h00;
  logic       bv  = 1'b0;
  logic       rd  = 1'b0;
  logic       clr = 1'b0;
  logic [9:0] event_out;
  logic       empty_out;
  logic [3:0] count_out;
  logic       overflow_out;

  always #5 clk = ~clk;

  kbd_scan_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_in(rst), .byte_in(kb), .byte_valid_in(bv),
    .rd_in(rd), .clr_ovf_in(clr), .event_out(event_out),
    .empty_out(empty_out), .count_out(count_out), .overflow_out(overflow_out)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte sequences are buffered and interpreted as a whole.
  logic [9:0] mq[$];
  logic [7:0] sbuf[$];
  bit         m_ovf = 0;
  logic [9:0] m_last = '0;
  longint     cyc = 0;
  longint     last_byte_cyc = 0;
  bit         held_v = 0;
  logic [8:0] held = '0;
  bit         model_ok = 0;

  function automatic void decode(output bit have, output logic [9:0] ev);
    int n;
    int i;
    have = 0;
    ev   = '0;
    n    = sbuf.size();
    if (sbuf[0] == 8'hE1) begin
      if (n == 8) begin have = 1; ev = 10'h1E1; sbuf.delete(); end
    end else if (sbuf[0] == 8'hF0) begin
      if (n == 2) begin have = 1; ev = {2'b10, sbuf[1]}; sbuf.delete(); end
    end else if (sbuf[0] == 8'hE0) begin
      i = 1;
      while (i < n && sbuf[i] == 8'hE0) i++;
      if (i < n) begin
        if (sbuf[i] != 8'hF0) begin
          have = 1; ev = {2'b01, sbuf[i]}; sbuf.delete();
        end else if (n == i + 2) begin
          have = 1; ev = {2'b11, sbuf[i+1]}; sbuf.delete();
        end
      end
    end else begin
      if (!(sbuf[0] inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
        have = 1; ev = {2'b00, sbuf[0]};
      end
      sbuf.delete();
    end
  endfunction

  initial begin
    bit         have;
    bit         pop;
    bit         set_ovf;
    logic [9:0] ev;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mq.delete(); sbuf.delete();
        m_ovf = 0; m_last = '0; held_v = 0; held = '0;
        model_ok = 1;
      end else begin
        have = 0;
        ev   = '0;
        if (bv) begin
          if (sbuf.size() > 0 && (cyc - last_byte_cyc) > TMO) sbuf.delete();
          last_byte_cyc = cyc;
          sbuf.push_back(kb);
          decode(have, ev);
        end
`ifdef KBD_REPEAT_FILTER_EN
        if (have) begin
          if (!ev[9]) begin
            if (held_v && held == ev[8:0]) have = 0;
            else begin held_v = 1; held = ev[8:0]; end
          end else if (held_v && held == ev[8:0]) begin
            held_v = 0;
          end
        end
`endif
        pop = rd && mq.size() > 0;
        if (mq.size() > 0) m_last = mq[0];
        set_ovf = have && mq.size() == DEPTH && !pop;
        if (pop) void'(mq.pop_front());
        if (have && !set_ovf) mq.push_back(ev);
        if (set_ovf) m_ovf = 1;
        else if (clr) m_ovf = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("count", 32'(count_out), 32'(mq.size()));
        check("empty", 32'(empty_out), 32'(mq.size() == 0));
        check("overflow", 32'(overflow_out), 32'(m_ovf));
        check("event", 32'(event_out), 32'(mq.size() > 0 ? mq[0] : m_last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    kb = b; bv = 1'b1;
    tick();
    bv = 1'b0;
  endtask

  task automatic pop1();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] makes [6] = '{8'h1C, 8'h15, 8'h75, 8'h14, 8'h4D, 8'h29};
    logic [7:0] chat  [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    int r;
    r = $urandom_range(0, 19);
    if (r < 3)       return 8'hE0;
    else if (r < 6)  return 8'hF0;
    else if (r == 6) return 8'hE1;
    else if (r < 9)  return chat[$urandom_range(0, 5)];
    else if (r < 16) return makes[$urandom_range(0, 5)];
    else             return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] nine [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", 32'(empty_out), 32'd1);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_ovf", 32'(overflow_out), 32'd0);
    check("rst_event", 32'(event_out), 32'd0);

    send(8'h1C);
    check("make_count", 32'(count_out), 32'd1);
    check("make_head", 32'(event_out), 32'h01C);
    send(8'hF0); send(8'h1C);
    check("brk_count", 32'(count_out), 32'd2);
    pop1();
    check("brk_head", 32'(event_out), 32'h21C);
    pop1();
    check("drain_empty", 32'(empty_out), 32'd1);
    check("hold_last", 32'(event_out), 32'h21C);

    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_head", 32'(event_out), 32'h175);
    pop1();
    check("extbrk_head", 32'(event_out), 32'h375);
    pop1();

    foreach (pause_seq[i]) send(pause_seq[i]);
    check("pause_count", 32'(count_out), 32'd1);
    check("pause_head", 32'(event_out), 32'h1E1);
    pop1();
    send(8'h1C);
    check("post_pause", 32'(event_out), 32'h01C);
    pop1();

    send(8'hAA); send(8'hFA); send(8'hE0);
    repeat (TMO + 4) tick();
    send(8'h1C);
    check("tmo_count", 32'(count_out), 32'd1);
    check("tmo_head", 32'(event_out), 32'h01C);
    pop1();

    foreach (nine[i]) send(nine[i]);
    check("full_count", 32'(count_out), 32'd8);
    check("full_ovf", 32'(overflow_out), 32'd1);
    check("full_head", 32'(event_out), 32'h015);
    kb = 8'h4D; bv = 1'b1; rd = 1'b1;
    tick();
    bv = 1'b0; rd = 1'b0;
    check("rdpush_count", 32'(count_out), 32'd8);
    check("rdpush_head", 32'(event_out), 32'h01D);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", 32'(overflow_out), 32'd0);
    rd = 1'b1;
    repeat (9) tick();
    rd = 1'b0;
    check("drain2_empty", 32'(empty_out), 32'd1);
    check("drain2_last", 32'(event_out), 32'h04D);

    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check("repeat_count", 32'(count_out), 32'(REP_EVENTS));
    rd = 1'b1;
    repeat (6) tick();
    rd = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      rd  = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 1) == 0) begin
        kb = pick_byte(); bv = 1'b1;
      end else begin
        bv = 1'b0;
      end
      tick();
      bv = 1'b0;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b0;
        repeat (TMO + 4) begin
          rd  = ($urandom_range(0, 3) == 0);
          clr = ($urandom_range(0, 15) == 0);
          tick();
        end
      end
    end
    rd = 1'b0; clr = 1'b0; rst = 1'b0; bv = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
